// File: rtl/sme_rng_bank_if.sv
// sme_rng_bank_if: seeding, take handshake and held randomness bank of
// sme_rng_bank. The consumer side (masked adder control) uses the master
// modport and the randomness bank uses the slave modport.
// W must equal N*G of the attached sme_rng_bank (192 at D=3, N=32).
interface sme_rng_bank_if #(
  parameter int W = 192
);
  logic          seed_en;   // load seed into generator state
  logic [31:0]   seed;      // new generator state (0 selects the built-in seed)
  logic          rng_take;  // transfer the full staging buffer to rng
  logic          rng_vld;   // staging buffer full, a take will succeed
  logic [W-1:0]  rng;       // held randomness bank
  logic          take_err;  // sticky: take requested while not valid

  modport master (
    output seed_en,
    output seed,
    output rng_take,
    input  rng_vld,
    input  rng,
    input  take_err
  );

  modport slave (
    input  seed_en,
    input  seed,
    input  rng_take,
    output rng_vld,
    output rng,
    output take_err
  );
endinterface

// File: rtl/sme_rng_bank.sv
// sme_rng_bank: guard-randomness source for the masked (SME) datapath.
// A 32-bit xorshift generator fills a staging buffer one word per cycle; a
// take copies the full buffer into a held output bank that stays stable for
// the consumer's whole multi-cycle operation.
// Build option: define SME_RNG_ZERO_EN to force the bank to all-zero on every
// successful take (unmasked functional / equivalence runs). Counter, valid,
// error and seeding behave the same in both builds.
module sme_rng_bank #(
  parameter int          D    = 3,
  parameter int          G    = D + D * (D - 1) / 2,
  parameter int          N    = 32,
  parameter logic [31:0] SEED = 32'h6A09E667
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  sme_rng_bank_if.slave   bus
);

  localparam int W     = N * G;
  localparam int WORDS = W / 32;
  localparam int CW    = $clog2(WORDS + 1);

  // Fill state: FILL while words are still missing, FULL once the buffer
  // holds WORDS fresh words. The state register is the registered rng_vld.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  state_e          st_q, st_d;
  logic [31:0]     x_q, x_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    rng_q, rng_d;
  logic            err_q, err_d;

  logic [31:0]     x1, x2, x3;
  logic [31:0]     seed_val;
  logic [W-1:0]    stage_flat;
  logic            step_en;
  logic            take_ok;
  logic            take_bad;
  logic            last_word;

  // A zero seed would lock the generator at zero forever, so it maps to SEED.
  assign seed_val = (bus.seed == 32'd0) ? SEED : bus.seed;

  // One xorshift step of the current state; shifts are logical, 32-bit.
  always_comb begin
    x1 = x_q ^ (x_q << 13);
    x2 = x1 ^ (x1 >> 17);
    x3 = x2 ^ (x2 << 5);
  end

  // The generator only advances while filling and not being reseeded, so a
  // full buffer stalls it and x holds.
  assign step_en   = (st_q == ST_FILL) && !bus.seed_en;
  assign take_ok   = bus.rng_take && (st_q == ST_FULL);
  assign take_bad  = bus.rng_take && (st_q != ST_FULL);
  assign last_word = (cnt_q == CW'(WORDS - 1));

  // Staging buffer: word gi captures the step output when the fill counter
  // points at it, so the first generated word lands at bits [31:0]. A reseed
  // simply restarts the counter; stale words are overwritten before the next
  // take can succeed.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      logic [31:0] word_q;

      // Capture the fresh word for this slot.
      always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
          word_q <= 32'd0;
        end else if (step_en && (cnt_q == CW'(gi))) begin
          word_q <= x3;
        end
      end

      assign stage_flat[32*gi +: 32] = word_q;
    end
  endgenerate

  // Next-state logic for generator, counter, fill FSM, bank and error flag.
  always_comb begin
    st_d  = st_q;
    x_d   = x_q;
    cnt_d = cnt_q;
    rng_d = rng_q;
    err_d = err_q;

    // A valid take completes with the old buffer even when a reseed lands
    // in the same cycle; the reseed then restarts the fill below.
    if (take_ok) begin
`ifdef SME_RNG_ZERO_EN
      rng_d = '0;
`else
      rng_d = stage_flat;
`endif
    end

    if (take_bad) begin
      err_d = 1'b1;
    end

    if (bus.seed_en) begin
      x_d   = seed_val;
      cnt_d = '0;
      st_d  = ST_FILL;
    end else if (take_ok) begin
      cnt_d = '0;
      st_d  = ST_FILL;
    end else if (step_en) begin
      x_d   = x3;
      cnt_d = cnt_q + 1'b1;
      if (last_word) begin
        st_d = ST_FULL;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      st_q  <= ST_FILL;
      x_q   <= SEED;
      cnt_q <= '0;
      rng_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      x_q   <= x_d;
      cnt_q <= cnt_d;
      rng_q <= rng_d;
      err_q <= err_d;
    end
  end

  assign bus.rng_vld  = (st_q == ST_FULL);
  assign bus.rng      = rng_q;
  assign bus.take_err = err_q;

endmodule

// File: tb/tb_sme_rng_bank.sv
// tb_sme_rng_bank: directed bench for sme_rng_bank (D=3, N=32, 6 words).
// Expected banks follow the xorshift recurrence; with SME_RNG_ZERO_EN defined
// every expected bank collapses to zero.
module tb_sme_rng_bank;
  localparam int          W     = 192;
  localparam int          WORDS = 6;
  localparam logic [31:0] SEED  = 32'h6A09E667;

  logic g_clk    = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  sme_rng_bank_if #(.W(W)) bus ();

  sme_rng_bank dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] f_seed;     // bank filled from SEED
  logic [W-1:0] f_one;      // bank filled from seed 1
  logic [W-1:0] f_cont;     // the 6 words following f_one
  logic [W-1:0] f_dead;     // bank filled from 0xDEADBEEF
  logic [31:0]  x_one_end;
  logic [31:0]  x_tmp;

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] a;
    a = x ^ (x << 13);
    a = a ^ (a >> 17);
    a = a ^ (a << 5);
    return a;
  endfunction

  task automatic model_fill(input logic [31:0] x0, output logic [W-1:0] w,
                            output logic [31:0] xe);
    logic [31:0] x;
    x = x0;
    w = '0;
    for (int i = 0; i < WORDS; i++) begin
      x = xs_step(x);
      w[32*i +: 32] = x;
    end
    xe = x;
  endtask

  function automatic logic [W-1:0] bank(input logic [W-1:0] v);
`ifdef SME_RNG_ZERO_EN
    return (v & '0);
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_seed(input logic [31:0] s);
    bus.seed_en = 1'b1;
    bus.seed    = s;
    tick();
    bus.seed_en = 1'b0;
    bus.seed    = 32'd0;
  endtask

  task automatic do_take();
    bus.rng_take = 1'b1;
    tick();
    bus.rng_take = 1'b0;
    $display("take: rng[63:0]=%h vld=%b err=%b", bus.rng[63:0], bus.rng_vld, bus.take_err);
  endtask

  // Counts edges until rng_vld rises, bounded at 40.
  task automatic wait_vld(output int k);
    k = 0;
    while (bus.rng_vld !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    bus.seed_en  = 1'b0;
    bus.seed     = 32'd0;
    bus.rng_take = 1'b0;
    g_resetn     = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.rng_vld, bus.take_err} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: vld,err=%b required 00", {bus.rng_vld, bus.take_err});
    end
    checks++;
    if (bus.rng !== '0) begin
      failures++;
      $display("FAIL reset_rng: rng[63:0]=%h required 0", bus.rng[63:0]);
    end
    g_resetn = 1'b1;
    $display("reset released");
  endtask

  task automatic test_seed_one();
    int k;
    logic [W-1:0] hand;
    logic [W-1:0] hb;
    hand = '0;
    hand[31:0]  = 32'h00042021;
    hand[63:32] = 32'h04080601;
    hb = bank(hand);
    do_seed(32'd1);
    wait_vld(k);
    checks++;
    if (k !== WORDS) begin
      failures++;
      $display("FAIL seed1_latency: cycles=%0d required %0d", k, WORDS);
    end
    do_take();
    checks++;
    if (bus.rng[63:0] !== hb[63:0]) begin
      failures++;
      $display("FAIL seed1_words: rng[63:0]=%h required %h", bus.rng[63:0], hb[63:0]);
    end
    checks++;
    if (bus.rng !== bank(f_one)) begin
      failures++;
      $display("FAIL seed1_bank: rng=%h required %h", bus.rng, bank(f_one));
    end
    checks++;
    if ({bus.rng_vld, bus.take_err} !== 2'b00) begin
      failures++;
      $display("FAIL seed1_after_take: vld,err=%b required 00", {bus.rng_vld, bus.take_err});
    end
  endtask

  task automatic test_seed_zero();
    int k;
    g_resetn = 1'b0;
    tick();
    g_resetn = 1'b1;
    wait_vld(k);
    checks++;
    if (k !== WORDS) begin
      failures++;
      $display("FAIL reset_fill_latency: cycles=%0d required %0d", k, WORDS);
    end
    do_take();
    checks++;
    if (bus.rng !== bank(f_seed)) begin
      failures++;
      $display("FAIL reset_stream: rng=%h required %h", bus.rng, bank(f_seed));
    end
    do_seed(32'd0);
    wait_vld(k);
    do_take();
    checks++;
    if (bus.rng !== bank(f_seed)) begin
      failures++;
      $display("FAIL seed0_stream: rng=%h required %h", bus.rng, bank(f_seed));
    end
  endtask

  task automatic test_early_take();
    int k;
    do_seed(32'd1);
    tick();
    tick();
    tick();
    checks++;
    if (bus.rng_vld !== 1'b0) begin
      failures++;
      $display("FAIL early_vld: vld=%b required 0", bus.rng_vld);
    end
    do_take();
    checks++;
    if (bus.take_err !== 1'b1) begin
      failures++;
      $display("FAIL early_err: take_err=%b required 1", bus.take_err);
    end
    checks++;
    if (bus.rng !== bank(f_seed)) begin
      failures++;
      $display("FAIL early_rng_held: rng=%h required %h", bus.rng, bank(f_seed));
    end
    wait_vld(k);
    checks++;
    if (k + 1 !== 3) begin
      failures++;
      $display("FAIL early_refill: cycles=%0d required 3", k + 1);
    end
  endtask

  task automatic test_hold();
    int k;
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rng_vld !== 1'b1 || bus.rng !== bank(f_seed)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hold_stable: unstable cycles=%0d required 0", bad);
    end
    do_take();
    checks++;
    if (bus.rng !== bank(f_one)) begin
      failures++;
      $display("FAIL hold_take: rng=%h required %h", bus.rng, bank(f_one));
    end
    checks++;
    if (bus.rng_vld !== 1'b0) begin
      failures++;
      $display("FAIL hold_vld_drop: vld=%b required 0", bus.rng_vld);
    end
    wait_vld(k);
    checks++;
    if (k !== WORDS) begin
      failures++;
      $display("FAIL hold_refill: cycles=%0d required %0d", k, WORDS);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bus.seed_en  = 1'b1;
    bus.seed     = 32'hDEADBEEF;
    bus.rng_take = 1'b1;
    tick();
    bus.seed_en  = 1'b0;
    bus.seed     = 32'd0;
    bus.rng_take = 1'b0;
    $display("seed+take: rng[63:0]=%h vld=%b", bus.rng[63:0], bus.rng_vld);
    checks++;
    if (bus.rng !== bank(f_cont)) begin
      failures++;
      $display("FAIL seedtake_old_buf: rng=%h required %h", bus.rng, bank(f_cont));
    end
    checks++;
    if ({bus.rng_vld, bus.take_err} !== 2'b01) begin
      failures++;
      $display("FAIL seedtake_flags: vld,err=%b required 01", {bus.rng_vld, bus.take_err});
    end
    wait_vld(k);
    checks++;
    if (k !== WORDS) begin
      failures++;
      $display("FAIL seedtake_refill: cycles=%0d required %0d", k, WORDS);
    end
    do_take();
    checks++;
    if (bus.rng !== bank(f_dead)) begin
      failures++;
      $display("FAIL seedtake_new_seed: rng=%h required %h", bus.rng, bank(f_dead));
    end
  endtask

  task automatic test_reset_midfill();
    int k;
    do_seed(32'd1);
    tick();
    tick();
    tick();
    g_resetn = 1'b0;
    tick();
    checks++;
    if ({bus.rng_vld, bus.take_err} !== 2'b00 || bus.rng !== '0) begin
      failures++;
      $display("FAIL midfill_reset: vld,err=%b rng[63:0]=%h required 00 and 0",
               {bus.rng_vld, bus.take_err}, bus.rng[63:0]);
    end
    g_resetn = 1'b1;
    wait_vld(k);
    checks++;
    if (k !== WORDS) begin
      failures++;
      $display("FAIL midfill_refill: cycles=%0d required %0d", k, WORDS);
    end
    do_take();
    checks++;
    if (bus.rng !== bank(f_seed)) begin
      failures++;
      $display("FAIL midfill_stream: rng=%h required %h", bus.rng, bank(f_seed));
    end
  endtask

  initial begin
    bus.seed_en  = 1'b0;
    bus.seed     = 32'd0;
    bus.rng_take = 1'b0;
    model_fill(SEED, f_seed, x_tmp);
    model_fill(32'd1, f_one, x_one_end);
    model_fill(x_one_end, f_cont, x_tmp);
    model_fill(32'hDEADBEEF, f_dead, x_tmp);

    test_reset();
    test_seed_one();
    test_seed_zero();
    test_early_take();
    test_hold();
    test_back_to_back();
    test_reset_midfill();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
